// File: rtl/booth_recoder_if.sv
// Booth-digit producer interface: operand handshake in, digit handshake out.
// The "slave" modport is the recoder's view; "master" is the environment's.
interface booth_recoder_if #(
    parameter int WIDTH = 3
);
    localparam int NDIG = (WIDTH + 1) / 2;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mplr;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       digit;
    logic [IDXW-1:0]  digit_idx;
    logic             digit_last;
    logic             busy;

    modport slave (
        input  in_valid,
        input  mplr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output digit,
        output digit_idx,
        output digit_last,
        output busy
    );

    modport master (
        output in_valid,
        output mplr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  digit,
        input  digit_idx,
        input  digit_last,
        input  busy
    );
endinterface

// File: rtl/booth_recoder.sv
// Serial radix-4 Booth recoder. Takes one signed multiplier operand and
// emits its Booth digits least-significant first, one per output handshake.
// Digit codes: 000=0, 001=+M, 010=+2M, 011=-2M, 100=-M.
// Optional feature macro: BOOTH_RECODER_ZERO_SKIP_EN -- zero digits other
// than the final one are dropped internally (one cycle each, no out_valid).
module booth_recoder #(
    parameter int WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    booth_recoder_if.slave  bus
);
    localparam int NDIG = (WIDTH + 1) / 2;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int EXTW = 2 * NDIG;
    localparam int SRW  = EXTW + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);
    localparam logic FIRST_IS_LAST = (NDIG == 1);

`ifdef BOOTH_RECODER_ZERO_SKIP_EN
    typedef enum logic [1:0] {IDLE, EMIT, SKIP} state_t;
`else
    typedef enum logic [0:0] {IDLE, EMIT} state_t;
`endif

    state_t          state_q, state_d;
    logic [SRW-1:0]  sr_q, sr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [2:0]      digit_q, digit_d;
    logic            last_q, last_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic signed [WIDTH-1:0] mplr_s;
    logic [SRW-1:0]  sr_load;
    logic [SRW-1:0]  sr_adv;
    logic [IDXW-1:0] idx_adv;
    logic [2:0]      digit_load;
    logic [2:0]      digit_adv;
    logic            last_adv;
    logic            accept;

    // Map a Booth triplet {y(2i+1), y(2i), y(2i-1)} to its digit code.
    function automatic logic [2:0] recode(input logic [2:0] t);
        logic [2:0] c;
        case (t)
            3'b000, 3'b111: c = 3'b000;
            3'b001, 3'b010: c = 3'b001;
            3'b011:         c = 3'b010;
            3'b100:         c = 3'b011;
            default:        c = 3'b100;
        endcase
        return c;
    endfunction

    // Load value (sign-extended operand with the implicit y(-1)=0) and the
    // arithmetic shift-by-two used to step to the next digit.
    assign mplr_s     = bus.mplr;
    assign sr_load    = {EXTW'(mplr_s), 1'b0};
    assign sr_adv     = {sr_q[SRW-1], sr_q[SRW-1], sr_q[SRW-1:2]};
    assign idx_adv    = idx_q + IDXW'(1);
    assign digit_load = recode(sr_load[2:0]);
    assign digit_adv  = recode(sr_adv[2:0]);
    assign last_adv   = (idx_adv == LAST_IDX);
    assign accept     = (state_q == IDLE) && bus.in_valid && in_ready_q;

    // Next-state and datapath decode; status outputs are registered from
    // the next state so in_ready stays low until the first edge out of reset.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = sr_load;
                    idx_d   = '0;
                    digit_d = digit_load;
                    last_d  = FIRST_IS_LAST;
                    state_d = EMIT;
`ifdef BOOTH_RECODER_ZERO_SKIP_EN
                    if (digit_load == 3'b000 && !FIRST_IS_LAST) begin
                        state_d = SKIP;
                    end
`endif
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        sr_d    = sr_adv;
                        idx_d   = idx_adv;
                        digit_d = digit_adv;
                        last_d  = last_adv;
`ifdef BOOTH_RECODER_ZERO_SKIP_EN
                        if (digit_adv == 3'b000 && !last_adv) begin
                            state_d = SKIP;
                        end
`endif
                    end
                end
            end
`ifdef BOOTH_RECODER_ZERO_SKIP_EN
            SKIP: begin
                // Current digit is a non-final zero: step past it silently.
                sr_d    = sr_adv;
                idx_d   = idx_adv;
                digit_d = digit_adv;
                last_d  = last_adv;
                state_d = (digit_adv == 3'b000 && !last_adv) ? SKIP : EMIT;
            end
`endif
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
    end

    // State, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            digit_q     <= 3'b000;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            digit_q     <= digit_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.digit      = digit_q;
    assign bus.digit_idx  = idx_q;
    assign bus.digit_last = last_q;
endmodule
